seq_checker: RTL and testbench

SEQ_CHECKER -- requirements
Module: seq_checker

---
 rtl/seq_checker_pkg.sv | 44 ++++
 rtl/seq_sync.sv | 23 ++
 rtl/seq_checker.sv | 129 ++++++++++++
 tb/tb_seq_checker.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_checker_pkg.sv
// Shared definitions for the counter-sequence checker: FSM encoding, the
// checked sequence table and its index helpers.
package seq_checker_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } state_t;

    typedef struct packed {
        logic       hit;
        logic [2:0] idx;
    } hunt_t;

    localparam int         SEQ_LEN  = 8;
    localparam logic [2:0] LOOP_IDX = 3'd4;
    localparam logic [3:0] LOOP_END = 4'd11;

    // Entry n lives in bits [4n+3:4n]: 0,2,5,7 prefix then the 8,10,9,11 loop.
    localparam logic [4*SEQ_LEN-1:0] SEQ_TABLE =
        {4'd11, 4'd9, 4'd10, 4'd8, 4'd7, 4'd5, 4'd2, 4'd0};

    function automatic logic [3:0] seq_value(input logic [2:0] idx);
        return SEQ_TABLE[{idx, 2'b00} +: 4];
    endfunction

    function automatic logic [2:0] seq_next(input logic [2:0] idx);
        return (idx == 3'd7) ? LOOP_IDX : idx + 3'd1;
    endfunction

    function automatic hunt_t seq_find(input logic [3:0] v);
        hunt_t res;
        res = '0;
        for (int i = 0; i < SEQ_LEN; i++) begin
            if (seq_value(3'(i)) == v) begin
                res.hit = 1'b1;
                res.idx = 3'(i);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seq_sync.sv
// Two-flop synchronizer with asynchronous active-low reset to zero.
module seq_sync #(
    parameter int DATA_W = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] sync_p0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_p0 <= '0;
            q       <= '0;
        end else begin
            sync_p0 <= d;
            q       <= sync_p0;
        end
    end

endmodule

// File: rtl/seq_checker.sv
// Sequence checker for a 4-bit counter (0,2,5,7 then looping 8,10,9,11).
// Define SEQ_CHECKER_SYNC_EN to pass q_in/sample_en through a 2-flop synchronizer.
module seq_checker
    import seq_checker_pkg::*;
#(
    parameter int LOCK_CNT = 4,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       q_in,
    input  logic             sample_en,
    input  logic             clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [3:0]       expected,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] loop_count
);

    localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);

    logic [3:0] q_eval;
    logic       vld_eval;

`ifdef SEQ_CHECKER_SYNC_EN
    logic [4:0] sync_q;

    seq_sync #(.DATA_W(5)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   ({sample_en, q_in}),
        .q   (sync_q)
    );

    assign q_eval   = sync_q[3:0];
    assign vld_eval = sync_q[4];
`else
    assign q_eval   = q_in;
    assign vld_eval = sample_en;
`endif

    state_t     state, state_nx;
    logic [2:0] idx, idx_nx;
    logic [3:0] match_cnt, cnt_nx;
    logic       rehunt, err_nx, loop_inc;
    logic       match;
    hunt_t      hunt;

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        cnt_nx   = match_cnt;
        rehunt   = 1'b0;
        err_nx   = 1'b0;
        loop_inc = 1'b0;
        match    = (q_eval == seq_value(idx));
        hunt     = seq_find(q_eval);

        if (vld_eval) begin
            case (state)
                HUNT: rehunt = 1'b1;
                ACQ: begin
                    if (match) begin
                        idx_nx = seq_next(idx);
                        cnt_nx = match_cnt + 4'd1;
                        if (cnt_nx >= LOCK_TGT) state_nx = LOCKED;
                    end else begin
                        rehunt = 1'b1;
                    end
                end
                LOCKED: begin
                    if (match) begin
                        idx_nx   = seq_next(idx);
                        loop_inc = (q_eval == LOOP_END);
                    end else begin
                        err_nx = 1'b1;
                        rehunt = 1'b1;
                    end
                end
                default: rehunt = 1'b1;
            endcase

            // A mismatching sample is immediately re-used as a fresh hunt candidate.
            if (rehunt) begin
                if (hunt.hit) begin
                    state_nx = (LOCK_CNT == 1) ? LOCKED : ACQ;
                    idx_nx   = seq_next(hunt.idx);
                    cnt_nx   = 4'd1;
                end else begin
                    state_nx = HUNT;
                    idx_nx   = 3'd0;
                    cnt_nx   = 4'd0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= HUNT;
            idx        <= 3'd0;
            match_cnt  <= 4'd0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            expected   <= 4'd0;
            err_count  <= '0;
            loop_count <= '0;
        end else begin
            state     <= state_nx;
            idx       <= idx_nx;
            match_cnt <= cnt_nx;
            locked    <= (state_nx == LOCKED);
            err_pulse <= err_nx;
            expected  <= (state_nx == HUNT) ? 4'd0 : seq_value(idx_nx);

            if (clr)
                err_count <= '0;
            else if (err_nx && (err_count != '1))
                err_count <= err_count + 1'b1;

            if (clr)
                loop_count <= '0;
            else if (loop_inc)
                loop_count <= loop_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_seq_checker.sv
// Directed self-checking bench for seq_checker (LOCK_CNT=4, CNT_W=8).
module tb_seq_checker;

    localparam int CNT_W = 8;
`ifdef SEQ_CHECKER_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [3:0]       q_in = 4'd0;
    logic             sample_en = 1'b0;
    logic             clr = 1'b0;
    logic             locked;
    logic             err_pulse;
    logic [3:0]       expected;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] loop_count;

    int n_cmp = 0;
    int n_err = 0;

    seq_checker #(.LOCK_CNT(4), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .q_in       (q_in),
        .sample_en  (sample_en),
        .clr        (clr),
        .locked     (locked),
        .err_pulse  (err_pulse),
        .expected   (expected),
        .err_count  (err_count),
        .loop_count (loop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // One sample; returns at the falling edge after the checker has evaluated it.
    task automatic step(input logic [3:0] v, input logic c);
        @(negedge clk);
        q_in      = v;
        sample_en = 1'b1;
        clr       = (LAT == 0) ? c : 1'b0;
        @(negedge clk);
        sample_en = 1'b0;
        clr       = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            clr = (i == LAT - 1) ? c : 1'b0;
            @(negedge clk);
            clr = 1'b0;
        end
    endtask

    task automatic lock_prefix();
        step(4'd0, 1'b0);
        step(4'd2, 1'b0);
        step(4'd5, 1'b0);
        step(4'd7, 1'b0);
    endtask

    task automatic one_loop();
        step(4'd8, 1'b0);
        step(4'd10, 1'b0);
        step(4'd9, 1'b0);
        step(4'd11, 1'b0);
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_locked", locked, 0);
        check("rst_err_pulse", err_pulse, 0);
        check("rst_expected", expected, 0);
        check("rst_err_count", err_count, 0);
        check("rst_loop_count", loop_count, 0);
        rst = 1'b1;

        // Clean acquisition of the full sequence
        step(4'd0, 1'b0);
        check("acq0_expected", expected, 2);
        check("acq0_locked", locked, 0);
        step(4'd2, 1'b0);
        step(4'd5, 1'b0);
        check("acq3_locked", locked, 0);
        check("acq3_expected", expected, 7);
        step(4'd7, 1'b0);
        check("lock_locked", locked, 1);
        check("lock_expected", expected, 8);
        step(4'd8, 1'b0);
        step(4'd10, 1'b0);
        step(4'd9, 1'b0);
        check("loop_expected11", expected, 11);
        step(4'd11, 1'b0);
        check("loop1_count", loop_count, 1);
        check("loop1_expected", expected, 8);
        step(4'd8, 1'b0);
        check("loop_expected10", expected, 10);
        check("clean_err_count", err_count, 0);

        // Off-table value while locked
        step(4'd12, 1'b0);
        check("err12_pulse", err_pulse, 1);
        check("err12_count", err_count, 1);
        check("err12_locked", locked, 0);
        check("err12_expected", expected, 0);
        @(negedge clk);
        check("err12_pulse_clear", err_pulse, 0);
        one_loop();
        check("relock_locked", locked, 1);
        check("relock_expected", expected, 8);
        check("relock_loop_count", loop_count, 1);

        // In-table mismatch re-acquires from the same sample
        step(4'd8, 1'b0);
        step(4'd10, 1'b0);
        check("pre_rehunt_expected", expected, 9);
        step(4'd8, 1'b0);
        check("rehunt_pulse", err_pulse, 1);
        check("rehunt_err_count", err_count, 2);
        check("rehunt_locked", locked, 0);
        check("rehunt_expected", expected, 10);

        // sample_en low holds everything
        @(negedge clk);
        q_in = 4'd3;
        repeat (3) @(negedge clk);
        check("hold_expected", expected, 10);
        check("hold_err_pulse", err_pulse, 0);

        // ACQ mismatch to an off-table value: back to HUNT, no error
        step(4'd3, 1'b0);
        check("acq_miss_expected", expected, 0);
        check("acq_miss_err_count", err_count, 2);
        check("acq_miss_pulse", err_pulse, 0);

        // Asynchronous reset mid-ACQ
        step(4'd0, 1'b0);
        check("midacq_expected", expected, 2);
        async_reset();
        check("rst_acq_expected", expected, 0);
        check("rst_acq_err_count", err_count, 0);
        check("rst_acq_loop_count", loop_count, 0);
        check("rst_acq_locked", locked, 0);
        @(negedge clk);
        rst = 1'b1;

        // Asynchronous reset mid-LOCKED
        lock_prefix();
        check("midlock_locked", locked, 1);
        async_reset();
        check("rst_lock_locked", locked, 0);
        check("rst_lock_expected", expected, 0);
        check("rst_lock_err_pulse", err_pulse, 0);
        @(negedge clk);
        rst = 1'b1;

        // err_count saturation
        lock_prefix();
        repeat (300) begin
            step(4'd0, 1'b0);
            step(4'd2, 1'b0);
            step(4'd5, 1'b0);
            step(4'd7, 1'b0);
        end
        check("sat_err_count", err_count, 255);
        check("sat_locked", locked, 1);
        step(4'd0, 1'b1);
        check("clr_err_pulse", err_pulse, 1);
        check("clr_err_count", err_count, 0);
        check("clr_expected", expected, 2);

        // loop_count accumulation and wrap
        step(4'd2, 1'b0);
        step(4'd5, 1'b0);
        step(4'd7, 1'b0);
        repeat (70) one_loop();
        check("loop70_count", loop_count, 70);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_loop_count", loop_count, 0);
        check("clr_fsm_locked", locked, 1);
        check("clr_fsm_expected", expected, 8);
        repeat (255) one_loop();
        check("loop255_count", loop_count, 255);
        one_loop();
        check("loop_wrap_count", loop_count, 0);
        repeat (3) one_loop();
        check("loop3_count", loop_count, 3);
        step(4'd8, 1'b0);
        step(4'd10, 1'b0);
        step(4'd9, 1'b0);
        step(4'd11, 1'b1);
        check("clr_wins_loop", loop_count, 0);
        check("clr_wins_locked", locked, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
